// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multiport register file:
//   clearState_t  - background clear sequencer states (IDLE, CLEAR)
//   addrWidth()   - address width for a given register count (min 1 bit)
//   paramsValid() - legal parameter ranges, checked at elaboration by the top
// ---------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clearState_t;

   function automatic int addrWidth(input int numRegs);
      return (numRegs <= 2) ? 1 : $clog2(numRegs);
   endfunction

   function automatic bit paramsValid(input int dataWidth, input int numRegs,
                                      input int numPorts);
      return (dataWidth >= 1) && (numRegs >= 2) && (numRegs <= 256) &&
             (numPorts >= 1) && (numPorts <= 4);
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// ---------------------------------------------------------------------------
// regfile_clear_seq
// Background clear sequencer. A ctrl_clear pulse in IDLE starts a walk over
// every register index, one per cycle, then returns to IDLE. Requests that
// arrive while a walk is running are ignored.
// Ports:
//   clock         in   rising-edge clock
//   ctrl_reset_n  in   asynchronous active-low reset
//   ctrl_clear    in   start request (single-cycle pulse)
//   ctrl_busy     out  registered, high while the walk is running
//   clearStrobe   out  zero register clearIdx on the coming edge
//   clearIdx      out  register index being zeroed this cycle
// ---------------------------------------------------------------------------
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = addrWidth(NUM_REGS)
) (
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              ctrl_clear,
   output logic              ctrl_busy,
   output logic              clearStrobe,
   output logic [ADDR_W-1:0] clearIdx
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   clearState_t       state_reg;
   logic [ADDR_W-1:0] count_reg;
   logic              busy_reg;

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ctrl_clear) begin
                  state_reg <= CLEAR;
                  count_reg <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            CLEAR: begin
               // The last index is zeroed on the same edge that leaves CLEAR,
               // so busy spans exactly NUM_REGS cycles.
               if (count_reg == LAST_IDX) begin
                  state_reg <= IDLE;
                  count_reg <= '0;
                  busy_reg  <= 1'b0;
               end else begin
                  count_reg <= count_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               count_reg <= '0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl_busy   = busy_reg;
   assign clearStrobe = (state_reg == CLEAR);
   assign clearIdx    = count_reg;

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
// Parametrised register file: one write port, NUM_READ_PORTS combinational
// read ports, optional hardwired-zero register 0, optional write-to-read
// bypass, and a background clear that zeroes one entry per cycle.
// Ports:
//   clock             in   rising-edge clock
//   ctrl_reset_n      in   asynchronous active-low reset (array cleared)
//   ctrl_writeEnable  in   write request this cycle
//   ctrl_writeReg     in   write address
//   data_writeReg     in   write data
//   ctrl_readReg      in   packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   data_readReg      out  packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_clear        in   start background clear (pulse)
//   ctrl_busy         out  clear in progress, writes dropped while high
// ---------------------------------------------------------------------------
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REGS       = 32,
   parameter int NUM_READ_PORTS = 2,
   parameter int ZERO_REG       = 1,
   parameter int BYPASS         = 1,
   parameter int ADDR_W         = addrWidth(NUM_REGS)
) (
   input  logic                               clock,
   input  logic                               ctrl_reset_n,
   input  logic                               ctrl_writeEnable,
   input  logic [ADDR_W-1:0]                  ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]              data_writeReg,
   input  logic [NUM_READ_PORTS*ADDR_W-1:0]   ctrl_readReg,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] data_readReg,
   input  logic                               ctrl_clear,
   output logic                               ctrl_busy
);

   localparam int              ADDR_SPAN   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] NUM_REGS_W  = NUM_REGS[ADDR_W:0];
   localparam bit              HAS_ZERO    = (ZERO_REG != 0);
   localparam bit              HAS_BYPASS  = (BYPASS != 0);

   genvar gi;

   generate
      if (!paramsValid(DATA_WIDTH, NUM_REGS, NUM_READ_PORTS)) begin : g_badParams
         $error("regfile_multiport: parameter out of range");
      end
   endgenerate

   logic              clearStrobe;
   logic [ADDR_W-1:0] clearIdx;
   logic              wrAccept;

   regfile_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clearSeq (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .ctrl_clear   (ctrl_clear),
      .ctrl_busy    (ctrl_busy),
      .clearStrobe  (clearStrobe),
      .clearIdx     (clearIdx)
   );

   // A write lands only when idle, in range, and not aimed at hardwired r0.
   assign wrAccept = ctrl_writeEnable && !ctrl_busy &&
                     ({1'b0, ctrl_writeReg} < NUM_REGS_W) &&
                     !(HAS_ZERO && (ctrl_writeReg == '0));

   // Read view padded to the full address span so that any address indexes
   // a defined entry; padding entries are constant zero.
   logic [DATA_WIDTH-1:0] regView [ADDR_SPAN];

   generate
      for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_reg
         if (gi < NUM_REGS) begin : g_live
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic [DATA_WIDTH-1:0] value_reg;

            always_ff @(posedge clock or negedge ctrl_reset_n) begin
               if (!ctrl_reset_n) begin
                  value_reg <= '0;
               end else if (clearStrobe && (clearIdx == IDX)) begin
                  value_reg <= '0;
               end else if (wrAccept && (ctrl_writeReg == IDX)) begin
                  value_reg <= data_writeReg;
               end
            end

            assign regView[gi] = value_reg;
         end else begin : g_pad
            assign regView[gi] = '0;
         end
      end
   endgenerate

   generate
      for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
         logic [ADDR_W-1:0]     portAddr;
         logic [DATA_WIDTH-1:0] portData;

         assign portAddr = ctrl_readReg[gi*ADDR_W +: ADDR_W];

         always_comb begin
            portData = '0;
            // wrAccept already excludes r0 and out-of-range addresses, so
            // the forwarded value always respects the read rules below.
            if (HAS_BYPASS && wrAccept && (portAddr == ctrl_writeReg)) begin
               portData = data_writeReg;
            end else if (({1'b0, portAddr} < NUM_REGS_W) &&
                         !(HAS_ZERO && (portAddr == '0))) begin
               portData = regView[portAddr];
            end
         end

         assign data_readReg[gi*DATA_WIDTH +: DATA_WIDTH] = portData;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
// Three instances share one stimulus stream (all have a 5-bit address):
//   dutA: 32 regs, bypass on;  dutB: 32 regs, bypass off;  dutC: 24 regs.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NP = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            rstN;
   logic            we;
   logic            clr;
   logic [AW-1:0]   wAddr;
   logic [DW-1:0]   wData;
   logic [NP*AW-1:0] rAddr;
   logic [NP*DW-1:0] rdA, rdB, rdC;
   logic            busyA, busyB, busyC;

   int tests = 0;
   int fails = 0;
   int n;

   regfile_multiport #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
                       .ZERO_REG(1), .BYPASS(1)) dutA (
      .clock(clock), .ctrl_reset_n(rstN), .ctrl_writeEnable(we),
      .ctrl_writeReg(wAddr), .data_writeReg(wData), .ctrl_readReg(rAddr),
      .data_readReg(rdA), .ctrl_clear(clr), .ctrl_busy(busyA));

   regfile_multiport #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
                       .ZERO_REG(1), .BYPASS(0)) dutB (
      .clock(clock), .ctrl_reset_n(rstN), .ctrl_writeEnable(we),
      .ctrl_writeReg(wAddr), .data_writeReg(wData), .ctrl_readReg(rAddr),
      .data_readReg(rdB), .ctrl_clear(clr), .ctrl_busy(busyB));

   regfile_multiport #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_READ_PORTS(2),
                       .ZERO_REG(1), .BYPASS(1)) dutC (
      .clock(clock), .ctrl_reset_n(rstN), .ctrl_writeEnable(we),
      .ctrl_writeReg(wAddr), .data_writeReg(wData), .ctrl_readReg(rAddr),
      .data_readReg(rdC), .ctrl_clear(clr), .ctrl_busy(busyC));

   function automatic logic [31:0] port(input logic [63:0] v, input int p);
      return v[p*32 +: 32];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setRead(input int a0, input int a1);
      rAddr = {5'(a1), 5'(a0)};
   endtask

   task automatic doWrite(input int a, input logic [31:0] d);
      we = 1'b1; wAddr = 5'(a); wData = d;
      tick();
      we = 1'b0;
   endtask

   initial begin
      rstN = 1'b0; we = 1'b0; clr = 1'b0; wAddr = '0; wData = '0; rAddr = '0;

      // reset state
      #2;
      setRead(5, 31);
      #1;
      chk("rst_busyA", 32'(busyA), 32'd0);
      chk("rst_rdA_r5", port(rdA, 0), 32'd0);
      repeat (2) @(posedge clock);
      #3 rstN = 1'b1;
      tick();
      for (int a = 0; a < 32; a++) begin
         setRead(a, 31 - a);
         #1;
         chk($sformatf("rst_r%0d_p0", a), port(rdA, 0), 32'd0);
         chk($sformatf("rst_r%0d_p1", 31 - a), port(rdA, 1), 32'd0);
      end
      chk("idle_busyA", 32'(busyA), 32'd0);
      chk("idle_busyB", 32'(busyB), 32'd0);
      chk("idle_busyC", 32'(busyC), 32'd0);
      tick();

      // basic write / read on both ports
      setRead(5, 5);
      doWrite(5, 32'hDEADBEEF);
      #2;
      chk("wr_r5_A_p0", port(rdA, 0), 32'hDEADBEEF);
      chk("wr_r5_A_p1", port(rdA, 1), 32'hDEADBEEF);
      chk("wr_r5_B_p0", port(rdB, 0), 32'hDEADBEEF);

      // hardwired zero register
      setRead(0, 0);
      doWrite(0, 32'h00001234);
      #2;
      chk("r0_A_p0", port(rdA, 0), 32'd0);
      chk("r0_B_p1", port(rdB, 1), 32'd0);

      // same-cycle bypass vs no bypass
      we = 1'b1; wAddr = 5'd7; wData = 32'hA5A5A5A5; setRead(5, 7);
      #2;
      chk("byp_A_p1", port(rdA, 1), 32'hA5A5A5A5);
      chk("byp_C_p1", port(rdC, 1), 32'hA5A5A5A5);
      chk("nobyp_B_p1", port(rdB, 1), 32'd0);
      chk("byp_A_p0_other", port(rdA, 0), 32'hDEADBEEF);
      tick();
      we = 1'b0;
      #2;
      chk("nobyp_B_p1_next", port(rdB, 1), 32'hA5A5A5A5);

      // no forwarding of a write aimed at r0
      we = 1'b1; wAddr = 5'd0; wData = 32'hFFFFFFFF; setRead(0, 0);
      #2;
      chk("byp_r0_A", port(rdA, 0), 32'd0);
      tick();
      we = 1'b0;

      // out-of-range address on the 24-entry instance
      we = 1'b1; wAddr = 5'd30; wData = 32'h55; setRead(30, 30);
      #2;
      chk("oor_C_bypass", port(rdC, 0), 32'd0);
      chk("inr_A_bypass", port(rdA, 0), 32'h55);
      tick();
      we = 1'b0;
      #2;
      chk("oor_C_read", port(rdC, 1), 32'd0);
      chk("inr_A_read", port(rdA, 1), 32'h55);
      setRead(23, 0);
      doWrite(23, 32'h2323);
      #2;
      chk("last_C_r23", port(rdC, 0), 32'h2323);

      // fill r1..r31 with their index
      for (int i = 1; i < 32; i++) doWrite(i, 32'(i));
      setRead(1, 31);
      #2;
      chk("fill_r1", port(rdA, 0), 32'd1);
      chk("fill_r31", port(rdA, 1), 32'd31);

      // clear pulse together with a write to r3 (accepted, busy still low)
      we = 1'b1; wAddr = 5'd3; wData = 32'h333; clr = 1'b1;
      tick();
      for (int k = 1; k <= 32; k++) begin
         we = 1'b0; clr = 1'b0;
         chk($sformatf("clr_busyA_c%0d", k), 32'(busyA), 32'd1);
         if (k == 2) begin
            setRead(3, 4); #1;
            chk("clr_c2_r3", port(rdA, 0), 32'h333);
            chk("clr_c2_r4", port(rdA, 1), 32'd4);
         end
         if (k == 12) begin
            setRead(9, 20); #1;
            chk("clr_c12_r9", port(rdA, 0), 32'd0);
            chk("clr_c12_r20", port(rdA, 1), 32'd20);
            setRead(10, 11); #1;
            chk("clr_c12_r10", port(rdA, 0), 32'd0);
            chk("clr_c12_r11", port(rdA, 1), 32'd11);
         end
         if (k == 15) begin
            we = 1'b1; wAddr = 5'd25; wData = 32'hBAD; setRead(25, 25); #1;
            chk("busy_wr_nobyp", port(rdA, 0), 32'd25);
         end
         if (k == 17) begin
            setRead(25, 25); #1;
            chk("busy_wr_dropped", port(rdA, 0), 32'd25);
         end
         if (k == 20) clr = 1'b1;
         if (k == 24) chk("clr_busyC_c24", 32'(busyC), 32'd1);
         if (k == 25) chk("clr_busyC_c25", 32'(busyC), 32'd0);
         tick();
      end
      we = 1'b0; clr = 1'b0;
      chk("clr_done_busyA", 32'(busyA), 32'd0);
      chk("clr_done_busyB", 32'(busyB), 32'd0);
      for (int a = 0; a < 32; a++) begin
         setRead(a, 31 - a);
         #1;
         chk($sformatf("clr_done_r%0d", a), port(rdA, 0), 32'd0);
      end
      setRead(7, 31);
      #1;
      chk("clr_done_B_r7", port(rdB, 0), 32'd0);
      tick();

      // reset in the middle of a clear
      doWrite(5, 32'h77);
      doWrite(31, 32'h3131);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (4) tick();
      #2;
      chk("midclr_busyA", 32'(busyA), 32'd1);
      rstN = 1'b0;
      #1;
      chk("async_busyA", 32'(busyA), 32'd0);
      chk("async_busyB", 32'(busyB), 32'd0);
      setRead(5, 31);
      #1;
      chk("async_r5", port(rdA, 0), 32'd0);
      chk("async_r31", port(rdA, 1), 32'd0);
      tick();
      #2 rstN = 1'b1;
      tick();
      chk("post_rst_busyA", 32'(busyA), 32'd0);

      // a fresh clear runs the full length
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (busyA && n < 100) begin
         n++;
         tick();
      end
      chk("rerun_len", 32'(n), 32'd32);
      chk("rerun_busyC", 32'(busyC), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
